nfi_scheduler: RTL and testbench
================================

Name: nfi_scheduler

Overview:
- Next-generation next-field-iteration scheduler for the Game of Life core.
- Issues a one-cycle `o_go` to the field-update engine at a programmable rate, then waits for the engine's `i_nfi_done` before timing the next iteration.
- Command inputs (pause toggle, single step, speed up/down) are edge-detected, so a held button produces one action.
- Keeps a generation counter. Sits between the command decoder and the field-update engine.

Parameters:
- BASE_TICKS, default 1_000_000: iteration period in cycles at speed level 0.
- N_SPEEDS, default 8: number of speed levels. Level s gives period BASE_TICKS >> s. Requires (BASE_TICKS >> (N_SPEEDS-1)) >= 2.
- GEN_W, default 16: width of the generation counter.
- WD_CYCLES, default 65_536: watchdog limit. Used only with the optional feature.
- Derived: SPD_W = $clog2(N_SPEEDS); CNT_W = $clog2(BASE_TICKS+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_cmd_toggle_pause  in  1  level; each rising edge toggles pause.
- i_cmd_step  in  1  level; rising edge requests one iteration while paused.
- i_cmd_speed_up  in  1  level; rising edge increments speed level.
- i_cmd_speed_down  in  1  level; rising edge decrements speed level.
- i_NFI_allowed  in  1  high when the engine may start (e.g. not in VGA active read window).
- i_nfi_done  in  1  one-cycle pulse from the engine at iteration end.
- o_go  out  1  one-cycle start pulse.
- o_busy  out  1  high from the o_go cycle until the done cycle inclusive.
- o_paused  out  1  current pause state.
- o_speed  out  SPD_W  current speed level.
- o_gen_cnt  out  GEN_W  completed iterations, wraps.
- o_timeout  out  1  one-cycle watchdog pulse.

Behaviour:
- Reset values:
  - Outputs: o_go=0, o_busy=0, o_paused=0, o_speed=0, o_gen_cnt=0, o_timeout=0.
  - Internals: state=IDLE, cnt=0, step_pend=0, all edge-detect history registers=0.
  - Consequence: an input held high across reset release yields one edge on the first clock.
- Edge detect: edge = in & ~in_d (registered), one per rising edge. Takes effect in the cycle after the edge is sampled.
- Speed: edge up → o_speed = min(o_speed+1, N_SPEEDS-1); edge down → max(o_speed-1, 0).
  - Saturates; no wrap.
  - Up and down edges in the same cycle → no change.
  - Any actual speed change clears cnt to 0.
- Period P = BASE_TICKS >> o_speed, computed combinationally, CNT_W wide.
- FSM IDLE:
  - cnt increments when !o_paused & i_NFI_allowed; holds otherwise.
  - When cnt == P-1 and the increment condition holds: cnt←0, state←GO.
  - If paused and step_pend & i_NFI_allowed: step_pend←0, state←GO, cnt unchanged.
- FSM GO: o_go=1 for exactly this cycle; state←WAIT.
- FSM WAIT:
  - On i_nfi_done: o_gen_cnt←o_gen_cnt+1 (mod 2^GEN_W), state←IDLE, cnt←0.
  - cnt frozen while in WAIT.
- o_busy = (state==GO) | (state==WAIT).
- i_nfi_done in IDLE or GO is ignored; no count.
- step_pend:
  - Set by a step edge only while o_paused.
  - Cleared on use, or when pause is toggled off.
  - Step edge while running is ignored.
- Pause toggle during GO/WAIT: o_paused flips immediately; the in-flight iteration completes normally.
- Latency:
  - Running: o_go asserted exactly P cycles after entering IDLE with allowed held high.
  - Step: o_go two cycles after the step edge is registered (IDLE→GO).
- Asynchronous reset mid-iteration aborts to IDLE with no o_go and no count.

Optional Feature:
- Macro NFI_WATCHDOG_EN.
- Defined:
  - A watchdog counter runs in WAIT.
  - If WD_CYCLES cycles elapse without i_nfi_done: state←IDLE, cnt←0, o_timeout=1 for one cycle, o_gen_cnt unchanged.
  - The watchdog counter clears on entry to WAIT.
- Undefined: WAIT persists indefinitely; o_timeout tied 0; no watchdog logic.

Test Plan (BASE_TICKS=16, N_SPEEDS=4, done returned 3 cycles after o_go):
- Reset then allowed=1, no commands → o_go pulses every 16+1+3 cycles; o_gen_cnt reads 1,2,3 after each done.
- Hold toggle_pause high 10 cycles → o_paused=1 once, no further o_go. Pulse step twice → exactly two o_go, o_gen_cnt +2.
- 5 speed_up edges → o_speed saturates at 3, period 2; 5 speed_down edges → o_speed=0. Up and down edges in the same cycle → unchanged.
- allowed=0 for 20 cycles mid-count → cnt frozen; o_go delayed by 20 cycles.
- Pause during WAIT → done still increments o_gen_cnt, then no o_go. Spurious done in IDLE → o_gen_cnt unchanged.
- NFI_WATCHDOG_EN, WD_CYCLES=8, never assert done → o_timeout pulse 8 cycles after entering WAIT, state IDLE, o_gen_cnt unchanged. Reset asserted during WAIT → all outputs 0.

Source files
------------

// File: rtl/nfi_scheduler.sv
// Next-field-iteration scheduler: paces o_go pulses to the field-update engine and counts generations.
// Optional watchdog on the engine's done pulse is enabled by defining NFI_WATCHDOG_EN.
module nfi_scheduler #(
    parameter int BASE_TICKS = 1_000_000,
    parameter int N_SPEEDS   = 8,
    parameter int GEN_W      = 16,
    parameter int WD_CYCLES  = 65_536,
    localparam int SPD_W     = $clog2(N_SPEEDS),
    localparam int CNT_W     = $clog2(BASE_TICKS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_toggle_pause,
    input  logic             i_cmd_step,
    input  logic             i_cmd_speed_up,
    input  logic             i_cmd_speed_down,
    input  logic             i_NFI_allowed,
    input  logic             i_nfi_done,
    output logic             o_go,
    output logic             o_busy,
    output logic             o_paused,
    output logic [SPD_W-1:0] o_speed,
    output logic [GEN_W-1:0] o_gen_cnt,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [SPD_W-1:0] MAX_SPD = SPD_W'(N_SPEEDS - 1);

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s, period_s;
    logic               step_pend_r, step_pend_next_s;
    logic               paused_r, paused_next_s;
    logic [SPD_W-1:0]   speed_r, speed_next_s;
    logic [GEN_W-1:0]   gen_r, gen_next_s;
    logic               go_r, busy_r, timeout_r, timeout_next_s;
    logic [3:0]         cmd_s, cmd_d_r, edge_s;
    logic               spd_chg_s;

`ifdef NFI_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0]    wd_r, wd_next_s;
`else
    logic               unused_wd_s;
    assign unused_wd_s = ^32'(WD_CYCLES);
`endif

    assign cmd_s    = {i_cmd_toggle_pause, i_cmd_step, i_cmd_speed_up, i_cmd_speed_down};
    assign edge_s   = cmd_s & ~cmd_d_r;
    assign period_s = CNT_W'(BASE_TICKS >> speed_r);

    // Next-state logic: commands, speed, pause/step bookkeeping and the iteration FSM.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        step_pend_next_s = step_pend_r;
        paused_next_s    = paused_r;
        speed_next_s     = speed_r;
        gen_next_s       = gen_r;
        timeout_next_s   = 1'b0;
        spd_chg_s        = 1'b0;
`ifdef NFI_WATCHDOG_EN
        wd_next_s        = wd_r;
`endif

        // Simultaneous up and down edges cancel out; saturate at both ends.
        if (edge_s[1] && !edge_s[0] && (speed_r != MAX_SPD)) begin
            speed_next_s = speed_r + SPD_W'(1);
            spd_chg_s    = 1'b1;
        end else if (edge_s[0] && !edge_s[1] && (speed_r != SPD_W'(0))) begin
            speed_next_s = speed_r - SPD_W'(1);
            spd_chg_s    = 1'b1;
        end else begin
            speed_next_s = speed_r;
        end

        if (edge_s[3]) begin
            paused_next_s = ~paused_r;
        end else begin
            paused_next_s = paused_r;
        end

        if (edge_s[2] && paused_r) begin
            step_pend_next_s = 1'b1;
        end else begin
            step_pend_next_s = step_pend_r;
        end

        if (edge_s[3] && paused_r) begin
            step_pend_next_s = 1'b0;
        end else begin
            step_pend_next_s = step_pend_next_s;
        end

        unique case (state_r)
            IDLE: begin
                if (!paused_r && i_NFI_allowed) begin
                    if (cnt_r == (period_s - CNT_W'(1))) begin
                        cnt_next_s   = CNT_W'(0);
                        state_next_s = GO;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_W'(1);
                    end
                end else if (paused_r && step_pend_r && i_NFI_allowed) begin
                    step_pend_next_s = 1'b0;
                    state_next_s     = GO;
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            GO: begin
                state_next_s = WAIT;
`ifdef NFI_WATCHDOG_EN
                wd_next_s    = WD_W'(0);
`endif
            end
            WAIT: begin
                if (i_nfi_done) begin
                    gen_next_s   = gen_r + GEN_W'(1);
                    cnt_next_s   = CNT_W'(0);
                    state_next_s = IDLE;
`ifdef NFI_WATCHDOG_EN
                end else if (wd_r == WD_W'(WD_CYCLES - 1)) begin
                    timeout_next_s = 1'b1;
                    cnt_next_s     = CNT_W'(0);
                    state_next_s   = IDLE;
                end else begin
                    wd_next_s = wd_r + WD_W'(1);
                end
`else
                end else begin
                    state_next_s = WAIT;
                end
`endif
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_W'(0);
            end
        endcase

        // A real speed change restarts the period so the new rate applies cleanly.
        if (spd_chg_s) begin
            cnt_next_s = CNT_W'(0);
        end else begin
            cnt_next_s = cnt_next_s;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_W'(0);
            step_pend_r <= 1'b0;
            paused_r    <= 1'b0;
            speed_r     <= SPD_W'(0);
            gen_r       <= GEN_W'(0);
            go_r        <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            cmd_d_r     <= 4'b0000;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            step_pend_r <= step_pend_next_s;
            paused_r    <= paused_next_s;
            speed_r     <= speed_next_s;
            gen_r       <= gen_next_s;
            go_r        <= (state_next_s == GO);
            busy_r      <= (state_next_s == GO) || (state_next_s == WAIT);
            timeout_r   <= timeout_next_s;
            cmd_d_r     <= cmd_s;
        end
    end

`ifdef NFI_WATCHDOG_EN
    // Watchdog counter for the WAIT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_r <= WD_W'(0);
        end else begin
            wd_r <= wd_next_s;
        end
    end
`endif

    assign o_go      = go_r;
    assign o_busy    = busy_r;
    assign o_paused  = paused_r;
    assign o_speed   = speed_r;
    assign o_gen_cnt = gen_r;
    assign o_timeout = timeout_r;

endmodule

// File: tb/tb_nfi_scheduler.sv
// Directed bench for nfi_scheduler (BASE_TICKS=16, N_SPEEDS=4); engine answers 3 cycles after o_go.
module tb_nfi_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tgl, stp, up, dn, allowed, done;
    logic        o_go, o_busy, o_paused, o_timeout;
    logic [1:0]  o_speed;
    logic [15:0] o_gen_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int gen_model = 0;
    logic [15:0] gen_q[$];

    nfi_scheduler #(.BASE_TICKS(16), .N_SPEEDS(4), .GEN_W(16), .WD_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_toggle_pause(tgl), .i_cmd_step(stp),
        .i_cmd_speed_up(up), .i_cmd_speed_down(dn),
        .i_NFI_allowed(allowed), .i_nfi_done(done),
        .o_go(o_go), .o_busy(o_busy), .o_paused(o_paused),
        .o_speed(o_speed), .o_gen_cnt(o_gen_cnt), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_go(input string tag, input int exp_n);
        int n;
        n = 0;
        while (!o_go && n < 200) begin
            tick();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    task automatic engine_done(input int dly);
        tick();
        check("busy_in_wait", o_busy, 1);
        check("go_one_cycle", o_go, 0);
        repeat (dly - 1) tick();
        done = 1'b1;
        gen_model++;
        gen_q.push_back(16'(gen_model));
        tick();
        done = 1'b0;
        check("gen_cnt", o_gen_cnt, gen_q.pop_front());
        check("busy_after_done", o_busy, 0);
    endtask

    task automatic idle_cycles(input int n, output int gos);
        gos = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_go) gos++;
        end
    endtask

    task automatic pulse(input int which);
        if (which == 0) tgl = 1'b1;
        else if (which == 1) up = 1'b1;
        else if (which == 2) dn = 1'b1;
        else begin up = 1'b1; dn = 1'b1; end
        tick();
        tgl = 1'b0; up = 1'b0; dn = 1'b0;
    endtask

    initial begin
        int gos;
        int n;
        rst_n = 1'b0; tgl = 1'b0; stp = 1'b0; up = 1'b0; dn = 1'b0;
        allowed = 1'b1; done = 1'b0;
        repeat (3) tick();
        check("rst_go", o_go, 0);
        check("rst_busy", o_busy, 0);
        check("rst_paused", o_paused, 0);
        check("rst_speed", o_speed, 0);
        check("rst_gen", o_gen_cnt, 0);
        check("rst_timeout", o_timeout, 0);
        rst_n = 1'b1;

        // Free-running: 16 cycles in IDLE per iteration.
        wait_go("first_go_lat", 16);
        for (int i = 0; i < 3; i++) begin
            engine_done(3);
            wait_go("run_period", 16);
        end
        engine_done(3);

        // Held toggle gives a single pause.
        tgl = 1'b1;
        idle_cycles(10, gos);
        tgl = 1'b0;
        check("pause_once", o_paused, 1);
        check("pause_no_go", gos, 0);
        idle_cycles(30, gos);
        check("paused_idle_no_go", gos, 0);

        for (int i = 0; i < 2; i++) begin
            stp = 1'b1;
            tick();
            stp = 1'b0;
            wait_go("step_lat", 1);
            engine_done(3);
        end
        idle_cycles(30, gos);
        check("after_steps_no_go", gos, 0);

        // Speed saturation at the top, then period 2.
        for (int i = 0; i < 5; i++) begin
            pulse(1);
            tick();
        end
        check("speed_sat_hi", o_speed, 3);
        pulse(0);
        wait_go("fast_first", 2);
        engine_done(3);
        wait_go("fast_period", 2);
        engine_done(3);
        pulse(0);
        check("repause", o_paused, 1);
        for (int i = 0; i < 5; i++) begin
            pulse(2);
            tick();
        end
        check("speed_sat_lo", o_speed, 0);
        pulse(1);
        check("speed_up1", o_speed, 1);
        tick();
        pulse(3);
        check("speed_updown", o_speed, 1);
        tick();
        pulse(2);
        check("speed_down1", o_speed, 0);
        tick();

        // Allowed low for 20 cycles freezes the count.
        pulse(0);
        check("unpause", o_paused, 0);
        idle_cycles(5, gos);
        allowed = 1'b0;
        idle_cycles(20, n);
        gos += n;
        allowed = 1'b1;
        check("disallow_no_go", gos, 0);
        wait_go("disallow_rest", 11);
        engine_done(3);

        // Pause during WAIT: iteration still completes.
        wait_go("pre_wait_pause", 16);
        pulse(0);
        check("pause_in_wait", o_paused, 1);
        check("busy_pause_wait", o_busy, 1);
        engine_done(2);
        idle_cycles(40, gos);
        check("paused_after_wait", gos, 0);

        done = 1'b1;
        gen_q.push_back(16'(gen_model));
        tick();
        done = 1'b0;
        check("spurious_done", o_gen_cnt, gen_q.pop_front());
        check("spurious_busy", o_busy, 0);

        // Asynchronous reset during WAIT.
        pulse(0);
        wait_go("pre_reset_go", 16);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_go", o_go, 0);
        check("arst_busy", o_busy, 0);
        check("arst_paused", o_paused, 0);
        check("arst_speed", o_speed, 0);
        check("arst_gen", o_gen_cnt, 0);
        check("arst_timeout", o_timeout, 0);
        gen_model = 0;
        gen_q.delete();
        tick();
        rst_n = 1'b1;

        wait_go("post_reset_go", 16);
`ifdef NFI_WATCHDOG_EN
        n = 0;
        while (!o_timeout && n < 50) begin
            tick();
            n++;
        end
        check("wd_latency", n, 9);
        check("wd_busy", o_busy, 0);
        check("wd_gen", o_gen_cnt, 0);
        tick();
        check("wd_pulse_len", o_timeout, 0);
`else
        gos = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_timeout) gos++;
        end
        check("no_wd_timeout", gos, 0);
        check("no_wd_busy", o_busy, 1);
        check("no_wd_gen", o_gen_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
